imem_load_arbiter: RTL and testbench

Single-port arbiter and program loader in front of the pipelined CPU's 64-word instruction memory. It shares the memory's one address/data port between the IF-stage fetch path and a word-streaming loader (debug/boot host). While a load is in progress it stalls the pipeline front end. The block sits between the IF stage, the loader interface and the instruction memory macro. The memory macro has an asynchronous (unregistered) read and a synchronous write.

---
 rtl/imem_load_arbiter.sv | 137 +++++++++++++
 tb/tb_imem_load_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter
// Shares the single instruction-memory port between IF-stage fetches and a
// word-streaming program loader. The front end stalls while a load is active.
module imem_load_arbiter #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic [31:0]   if_pc,
    output logic [DW-1:0] if_inst,
    output logic          if_stall,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_base,
    input  logic [AW:0]   ld_len,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          ld_abort,
    output logic          ld_busy,
    output logic          ld_done,
    output logic [AW:0]   ld_count,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    // Longest load the memory can hold; longer requests saturate here.
    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] ptr;
    logic [AW:0]   remaining;
    logic          start_ok;
    logic          handshake;

    // Byte-offset and high PC bits do not take part in word addressing.
    logic unused_pc;
    assign unused_pc = ^{if_pc[31:AW+2], if_pc[1:0]};

    // A zero-length request is not a load at all.
    assign start_ok = (state == IDLE) && ld_start && (ld_len != '0);

    // Abort wins over a word offered in the same cycle, so nothing is written.
    assign handshake = (state == LOAD) && ld_valid && !ld_abort;

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: DONE is a single fence cycle before fetch resumes.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (ld_abort) begin
                    next_state = IDLE;
                end else if (ld_valid && (remaining == (AW+1)'(1))) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Load pointer, words-remaining and words-written bookkeeping.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ptr       <= '0;
            remaining <= '0;
            ld_count  <= '0;
        end else if (start_ok) begin
            ptr       <= ld_base;
            remaining <= (ld_len > MAX_LEN) ? MAX_LEN : ld_len;
            ld_count  <= '0;
        end else if (handshake) begin
            ptr       <= ptr + AW'(1);
            remaining <= remaining - (AW+1)'(1);
            ld_count  <= ld_count + (AW+1)'(1);
        end
    end

    // Port steering and status outputs, all decoded from the current state.
    always_comb begin
        mem_addr  = ptr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if_inst   = '0;
        if_stall  = 1'b1;
        ld_ready  = 1'b0;
        ld_busy   = 1'b0;
        ld_done   = 1'b0;
        case (state)
            IDLE: begin
                mem_addr = if_pc[AW+1:2];
                if_inst  = mem_rdata;
                if_stall = 1'b0;
            end
            LOAD: begin
                mem_wdata = ld_data;
                mem_we    = handshake;
                ld_ready  = 1'b1;
                ld_busy   = 1'b1;
            end
            DONE: begin
                ld_done = !ld_abort;
            end
            default: begin
                if_stall = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// tb_imem_load_arbiter
// Directed bench with a behavioural memory and a write scoreboard.
module tb_imem_load_arbiter;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_stall;
    logic        ld_start;
    logic [5:0]  ld_base;
    logic [6:0]  ld_len;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        ld_abort;
    logic        ld_busy;
    logic        ld_done;
    logic [6:0]  ld_count;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    logic        preloadWe;
    logic [5:0]  preloadAddr;
    logic [31:0] preloadData;

    logic [37:0] sbq [$];
    int          vectors = 0;
    int          miscompares = 0;

    imem_load_arbiter #(.AW(6), .DW(32)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .if_stall  (if_stall),
        .ld_start  (ld_start),
        .ld_base   (ld_base),
        .ld_len    (ld_len),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .ld_abort  (ld_abort),
        .ld_busy   (ld_busy),
        .ld_done   (ld_done),
        .ld_count  (ld_count),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clock = ~clock;

    // Memory macro model: asynchronous read, synchronous write plus a bench preload port.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clock) begin
        if (preloadWe) begin
            mem[preloadAddr] <= preloadData;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every memory write must match the next expected write, and needs ld_valid.
    always @(negedge clock) begin
        if (mem_we) begin
            if (sbq.size() == 0) begin
                checkOutput("sb_unexpected_write", {26'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [37:0] e;
                e = sbq.pop_front();
                checkOutput("sb_addr", {26'd0, mem_addr}, {26'd0, e[37:32]});
                checkOutput("sb_data", mem_wdata, e[31:0]);
            end
            checkOutput("we_needs_valid", 32'(ld_valid), 32'd1);
        end
        checkOutput("busy_done_excl", 32'(ld_busy & ld_done), 32'd0);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic start, input logic [5:0] base, input logic [6:0] len);
        ld_start = start;
        ld_base  = base;
        ld_len   = len;
    endtask

    task automatic pushWord(input logic [5:0] addr, input logic [31:0] data);
        ld_valid = 1'b1;
        ld_data  = data;
        sbq.push_back({addr, data});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] wa;
        logic [5:0] vpat;
        resetn = 1'b0;
        if_pc = 32'h0;
        ld_start = 1'b0;
        ld_base = '0;
        ld_len = '0;
        ld_valid = 1'b0;
        ld_data = '0;
        ld_abort = 1'b0;
        preloadWe = 1'b1;
        preloadAddr = 6'd5;
        preloadData = 32'h2008_0005;
        tick();
        preloadAddr = 6'd12;
        preloadData = 32'hDEAD_BEEF;
        tick();
        preloadWe = 1'b0;

        // Reset state
        settle();
        checkOutput("rst_busy", 32'(ld_busy), 32'd0);
        checkOutput("rst_done", 32'(ld_done), 32'd0);
        checkOutput("rst_ready", 32'(ld_ready), 32'd0);
        checkOutput("rst_stall", 32'(if_stall), 32'd0);
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_count", 32'(ld_count), 32'd0);
        resetn = 1'b1;
        if_pc = 32'h14;
        #1;
        checkOutput("fetch5_inst", if_inst, 32'h2008_0005);
        checkOutput("fetch5_addr", {26'd0, mem_addr}, 32'd5);
        checkOutput("fetch5_stall", 32'(if_stall), 32'd0);
        tick();

        // Basic three-word load at base 4
        $display("[TB] basic load");
        applyStimulus(1'b1, 6'd4, 7'd3);
        settle();
        checkOutput("basic_pre_stall", 32'(if_stall), 32'd0);
        tick();
        applyStimulus(1'b0, 6'd0, 7'd0);
        pushWord(6'd4, 32'hA);
        settle();
        checkOutput("basic_ready", 32'(ld_ready), 32'd1);
        checkOutput("basic_stall1", 32'(if_stall), 32'd1);
        checkOutput("basic_nop", if_inst, 32'd0);
        tick();
        pushWord(6'd5, 32'hB);
        settle();
        checkOutput("basic_stall2", 32'(if_stall), 32'd1);
        tick();
        pushWord(6'd6, 32'hC);
        settle();
        checkOutput("basic_stall3", 32'(if_stall), 32'd1);
        checkOutput("basic_nodone", 32'(ld_done), 32'd0);
        tick();
        ld_valid = 1'b0;
        settle();
        checkOutput("basic_done", 32'(ld_done), 32'd1);
        checkOutput("basic_stall4", 32'(if_stall), 32'd1);
        checkOutput("basic_ready_done", 32'(ld_ready), 32'd0);
        checkOutput("basic_count", 32'(ld_count), 32'd3);
        tick();
        if_pc = 32'h18;
        settle();
        checkOutput("basic_fetch6", if_inst, 32'hC);
        checkOutput("basic_stall_off", 32'(if_stall), 32'd0);
        checkOutput("basic_done_off", 32'(ld_done), 32'd0);
        tick();

        // Wrap-around with gaps in ld_valid
        $display("[TB] wrap and backpressure");
        applyStimulus(1'b1, 6'd62, 7'd4);
        tick();
        applyStimulus(1'b0, 6'd0, 7'd0);
        wa = 6'd62;
        vpat = 6'b110101;
        for (int i = 0; i < 6; i++) begin
            if (vpat[i]) begin
                pushWord(wa, 32'h100 + 32'(i));
                wa = wa + 6'd1;
            end else begin
                ld_valid = 1'b0;
                ld_data = 32'hBAD0 + 32'(i);
            end
            settle();
            checkOutput("wrap_busy", 32'(ld_busy), 32'd1);
            tick();
        end
        ld_valid = 1'b0;
        settle();
        checkOutput("wrap_done", 32'(ld_done), 32'd1);
        checkOutput("wrap_count", 32'(ld_count), 32'd4);
        tick();
        if_pc = 32'd248;
        #1;
        checkOutput("wrap_fetch62", if_inst, 32'h100);
        if_pc = 32'd0;
        #1;
        checkOutput("wrap_fetch0", if_inst, 32'h104);
        if_pc = 32'd4;
        #1;
        checkOutput("wrap_fetch1", if_inst, 32'h105);
        checkOutput("wrap_count_hold", 32'(ld_count), 32'd4);
        tick();

        // Abort together with the third word
        $display("[TB] abort");
        applyStimulus(1'b1, 6'd10, 7'd10);
        tick();
        applyStimulus(1'b0, 6'd0, 7'd0);
        pushWord(6'd10, 32'h200);
        tick();
        pushWord(6'd11, 32'h201);
        tick();
        ld_valid = 1'b1;
        ld_data = 32'h202;
        ld_abort = 1'b1;
        settle();
        checkOutput("abort_we", 32'(mem_we), 32'd0);
        tick();
        ld_abort = 1'b0;
        ld_valid = 1'b0;
        if_pc = 32'd48;
        settle();
        checkOutput("abort_stall", 32'(if_stall), 32'd0);
        checkOutput("abort_busy", 32'(ld_busy), 32'd0);
        checkOutput("abort_nodone", 32'(ld_done), 32'd0);
        checkOutput("abort_count", 32'(ld_count), 32'd2);
        checkOutput("abort_keep12", if_inst, 32'hDEAD_BEEF);
        if_pc = 32'd44;
        #1;
        checkOutput("abort_fetch11", if_inst, 32'h201);
        tick();

        // Zero length is ignored
        $display("[TB] corner lengths");
        applyStimulus(1'b1, 6'd3, 7'd0);
        tick();
        applyStimulus(1'b0, 6'd0, 7'd0);
        ld_valid = 1'b1;
        ld_data = 32'hBAD;
        settle();
        checkOutput("len0_stall", 32'(if_stall), 32'd0);
        checkOutput("len0_busy", 32'(ld_busy), 32'd0);
        checkOutput("len0_count", 32'(ld_count), 32'd2);
        ld_valid = 1'b0;
        tick();

        // Oversize length saturates to 64 words
        applyStimulus(1'b1, 6'd0, 7'd100);
        tick();
        applyStimulus(1'b0, 6'd0, 7'd0);
        for (int i = 0; i < 64; i++) begin
            pushWord(6'(i), 32'h1000 + 32'(i));
            settle();
            checkOutput("sat_busy", 32'(ld_busy), 32'd1);
            tick();
        end
        ld_valid = 1'b0;
        settle();
        checkOutput("sat_done", 32'(ld_done), 32'd1);
        checkOutput("sat_count", 32'(ld_count), 32'd64);
        tick();
        settle();
        checkOutput("sat_idle", 32'(if_stall), 32'd0);
        tick();

        // Asynchronous reset in the middle of a five-word load
        $display("[TB] async reset mid-load");
        applyStimulus(1'b1, 6'd20, 7'd5);
        tick();
        applyStimulus(1'b0, 6'd0, 7'd0);
        pushWord(6'd20, 32'h300);
        tick();
        pushWord(6'd21, 32'h301);
        tick();
        ld_valid = 1'b1;
        ld_data = 32'h302;
        resetn = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(ld_busy), 32'd0);
        checkOutput("arst_ready", 32'(ld_ready), 32'd0);
        checkOutput("arst_stall", 32'(if_stall), 32'd0);
        checkOutput("arst_we", 32'(mem_we), 32'd0);
        checkOutput("arst_count", 32'(ld_count), 32'd0);
        settle();
        resetn = 1'b1;
        ld_valid = 1'b0;
        if_pc = 32'd80;
        #1;
        checkOutput("arst_fetch20", if_inst, 32'h300);
        if_pc = 32'd84;
        #1;
        checkOutput("arst_fetch21", if_inst, 32'h301);
        if_pc = 32'd88;
        #1;
        checkOutput("arst_fetch22", if_inst, 32'h1016);
        tick();
        applyStimulus(1'b1, 6'd30, 7'd1);
        tick();
        applyStimulus(1'b0, 6'd0, 7'd0);
        pushWord(6'd30, 32'h400);
        settle();
        checkOutput("post_busy", 32'(ld_busy), 32'd1);
        tick();
        ld_valid = 1'b0;
        settle();
        checkOutput("post_done", 32'(ld_done), 32'd1);
        checkOutput("post_count", 32'(ld_count), 32'd1);
        tick();

        checkOutput("sb_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
